// File: rtl/fifo_burst_writer_pkg.sv
// Shared constants for the FIFO-to-burst write path.
// State encoding is kept as plain localparams so legacy code can compare against raw values.
package fifo_burst_writer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/fifo_burst_writer_if.sv
// Burst write channel between the FIFO drainer and the memory/AXI write adapter.
// Address and data phases have independent valid/ready handshakes.
interface fifo_burst_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 4,
    parameter int DATA_WIDTH = 16
);

    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [LEN_WIDTH-1:0]  aw_len;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;

    modport master (
        output aw_addr, aw_len, aw_valid, w_data, w_valid, w_last,
        input  aw_ready, w_ready
    );

    modport slave (
        input  aw_addr, aw_len, aw_valid, w_data, w_valid, w_last,
        output aw_ready, w_ready
    );

endinterface

// File: rtl/fifo_burst_timer.sv
// Saturating idle counter; expired stays high once TIMEOUT counts have accumulated.
// TIMEOUT = 0 means the timer never expires.
module fifo_burst_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] STEP  = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + STEP;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/fifo_burst_writer.sv
// Drains a fill-reporting FIFO into burst writes: full MAX_BURST bursts when enough data
// is buffered, and a timeout-triggered partial burst when data sits idle too long.
module fifo_burst_writer
    import fifo_burst_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4,
    parameter int MAX_BURST  = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_rst,
    input  logic                  en,
    input  logic                  set_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  fifo_nempty,
    input  logic [DATA_DEPTH:0]   fifo_fill,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    fifo_burst_writer_if.master   bus,
    output logic                  busy,
    output logic                  flushing,
    output logic [15:0]           burst_count
);

    localparam logic [DATA_DEPTH:0] MAX_B   = (DATA_DEPTH + 1)'(MAX_BURST);
    localparam logic [DATA_DEPTH:0] CNT_ONE = (DATA_DEPTH + 1)'(1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [DATA_DEPTH:0]   beats;
    logic [DATA_DEPTH:0]   remaining;
    logic [DATA_DEPTH:0]   avail;
    logic                  partial;
    logic                  timer_expired;

    // The FIFO output register holds one word beyond what fifo_fill reports.
    assign avail   = fifo_fill + {{DATA_DEPTH{1'b0}}, fifo_nempty};
    assign partial = (state == ST_IDLE) && en && (avail != '0) && (avail < MAX_B);

    fifo_burst_timer #(
        .TIMEOUT(TIMEOUT)
    ) idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (sync_rst | ~partial),
        .enable  (partial),
        .expired (timer_expired)
    );

    assign bus.aw_valid = (state == ST_ADDR);
    assign bus.aw_addr  = burst_addr;
    assign bus.aw_len   = (state == ST_ADDR) ? LEN_WIDTH'(beats - CNT_ONE) : '0;
    assign bus.w_valid  = (state == ST_DATA) && fifo_nempty;
    assign bus.w_data   = fifo_data;
    assign bus.w_last   = (state == ST_DATA) && (remaining == CNT_ONE);
    assign fifo_re      = bus.w_valid && bus.w_ready;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            burst_addr  <= '0;
            beats       <= '0;
            remaining   <= '0;
            flushing    <= 1'b0;
            burst_count <= '0;
        end else if (sync_rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            burst_addr  <= '0;
            beats       <= '0;
            remaining   <= '0;
            flushing    <= 1'b0;
            burst_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && avail >= MAX_B) begin
                        beats      <= MAX_B;
                        remaining  <= MAX_B;
                        flushing   <= 1'b0;
                        burst_addr <= addr;
                        state      <= ST_ADDR;
                    end else if (en && TIMEOUT != 0 && partial && timer_expired) begin
                        beats      <= avail;
                        remaining  <= avail;
                        flushing   <= 1'b1;
                        burst_addr <= addr;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.aw_ready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fifo_re) begin
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            addr        <= addr + ADDR_WIDTH'(beats);
                            burst_count <= burst_count + 16'd1;
                            flushing    <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A software address load overrides the end-of-burst increment.
            if (set_addr) begin
                addr <= start_addr;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: a queue-based FIFO model feeds the DUT and
// every observed beat, address and status is compared against hand-derived values.
module tb_fifo_burst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync_rst;
    logic        en;
    logic        set_addr;
    logic [15:0] start_addr;
    logic        fifo_nempty;
    logic [4:0]  fifo_fill;
    logic [15:0] fifo_data;
    logic        fifo_re;
    logic        busy;
    logic        flushing;
    logic [15:0] burst_count;

    logic [15:0] fifoQ[$];
    logic [15:0] nextWord = 16'h1000;
    logic [15:0] expWord  = 16'h1000;
    int          popCount = 0;
    int          vectorCount = 0;
    int          missCount = 0;

    fifo_burst_writer_if #(.ADDR_WIDTH(16), .LEN_WIDTH(4), .DATA_WIDTH(16)) bus ();

    fifo_burst_writer #(
        .DATA_WIDTH(16), .DATA_DEPTH(4), .MAX_BURST(8),
        .LEN_WIDTH(4), .ADDR_WIDTH(16), .TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_rst    (sync_rst),
        .en          (en),
        .set_addr    (set_addr),
        .start_addr  (start_addr),
        .fifo_nempty (fifo_nempty),
        .fifo_fill   (fifo_fill),
        .fifo_data   (fifo_data),
        .fifo_re     (fifo_re),
        .bus         (bus),
        .busy        (busy),
        .flushing    (flushing),
        .burst_count (burst_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic refreshFifo();
        fifo_nempty = (fifoQ.size() > 0);
        fifo_data   = (fifoQ.size() > 0) ? fifoQ[0] : 16'h0;
        fifo_fill   = (fifoQ.size() > 0) ? 5'(fifoQ.size() - 1) : 5'd0;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            fifoQ.push_back(nextWord);
            nextWord++;
        end
        refreshFifo();
    endtask

    // Pop decision is sampled mid-cycle, the FIFO model updates just after the edge.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = fifo_re;
        @(posedge clk);
        #1;
        if (pop && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            popCount++;
        end
        refreshFifo();
        #1;
    endtask

    task automatic waitAw(input int limit);
        int n = 0;
        while (!bus.aw_valid && n < limit) begin
            tick();
            n++;
        end
        checkOutput("aw_seen", {31'b0, bus.aw_valid}, 32'd1);
    endtask

    task automatic watchBurst(input logic [15:0] expAddr, input logic [3:0] expLen, input bit expFlush,
                              input int nBeats, input int awDelay, input bit toggle,
                              input bit setOnLast, input bit dropEn);
        int beat = 0;
        int cyc = 0;
        int pops0;
        waitAw(40);
        checkOutput("aw_addr", {16'b0, bus.aw_addr}, {16'b0, expAddr});
        checkOutput("aw_len", {28'b0, bus.aw_len}, {28'b0, expLen});
        checkOutput("flushing", {31'b0, flushing}, {31'b0, expFlush});
        bus.aw_ready = 1'b0;
        for (int i = 0; i < awDelay; i++) begin
            tick();
            checkOutput("aw_hold_valid", {31'b0, bus.aw_valid}, 32'd1);
            checkOutput("aw_hold_addr", {16'b0, bus.aw_addr}, {16'b0, expAddr});
            checkOutput("aw_hold_len", {28'b0, bus.aw_len}, {28'b0, expLen});
        end
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        if (dropEn) en = 1'b0;
        pops0 = popCount;
        while (beat < nBeats && cyc < nBeats * 4 + 20) begin
            bus.w_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            checkOutput("fifo_re", {31'b0, fifo_re}, {31'b0, fifo_nempty & bus.w_ready});
            if (bus.w_valid && bus.w_ready) begin
                beat++;
                checkOutput("w_data", {16'b0, bus.w_data}, {16'b0, expWord});
                expWord++;
                checkOutput("w_last", {31'b0, bus.w_last}, (beat == nBeats) ? 32'd1 : 32'd0);
                if (setOnLast && beat == nBeats) begin
                    set_addr   = 1'b1;
                    start_addr = 16'h0100;
                end
            end
            tick();
            set_addr = 1'b0;
            cyc++;
        end
        bus.w_ready = 1'b0;
        checkOutput("beats", beat, nBeats);
        checkOutput("pops", popCount - pops0, nBeats);
        checkOutput("idle_after", {31'b0, busy}, 32'd0);
        checkOutput("flush_clear", {31'b0, flushing}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        rst = 1'b1; sync_rst = 1'b0; en = 1'b0; set_addr = 1'b0; start_addr = 16'h0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        refreshFifo();
        #12;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_aw_valid", {31'b0, bus.aw_valid}, 32'd0);
        checkOutput("rst_w_valid", {31'b0, bus.w_valid}, 32'd0);
        checkOutput("rst_count", {16'b0, burst_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Full burst from address 0
        en = 1'b1;
        applyStimulus(8);
        watchBurst(16'h0000, 4'd7, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("count_1", {16'b0, burst_count}, 32'd1);

        // Timeout flush of three words
        applyStimulus(3);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("flush_early", {31'b0, bus.aw_valid}, 32'd0);
        tick();
        checkOutput("flush_start", {31'b0, bus.aw_valid}, 32'd1);
        watchBurst(16'h0008, 4'd2, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0);

        // Backpressure on both channels
        applyStimulus(8);
        watchBurst(16'h000B, 4'd7, 1'b0, 8, 5, 1'b1, 1'b0, 1'b0);
        checkOutput("count_3", {16'b0, burst_count}, 32'd3);

        // Address wrap and load on the last beat
        set_addr = 1'b1; start_addr = 16'hFFFC;
        tick();
        set_addr = 1'b0;
        applyStimulus(16);
        watchBurst(16'hFFFC, 4'd7, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0);
        watchBurst(16'h0004, 4'd7, 1'b0, 8, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8);
        watchBurst(16'h0100, 4'd7, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0);

        // Enable gating, before and during a burst
        en = 1'b0;
        applyStimulus(16);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.aw_valid) seen++;
        end
        checkOutput("en_off_no_aw", seen, 0);
        en = 1'b1;
        watchBurst(16'h0108, 4'd7, 1'b0, 8, 0, 1'b0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.aw_valid) seen++;
        end
        checkOutput("en_drop_no_aw", seen, 0);
        checkOutput("count_7", {16'b0, burst_count}, 32'd7);

        // Synchronous reset after three beats of a burst
        en = 1'b1;
        waitAw(40);
        checkOutput("sr_aw_addr", {16'b0, bus.aw_addr}, 32'h0110);
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        bus.w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("sr_w_data", {16'b0, bus.w_data}, {16'b0, expWord});
            expWord++;
            tick();
        end
        bus.w_ready = 1'b0;
        en = 1'b0;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        checkOutput("sr_busy", {31'b0, busy}, 32'd0);
        checkOutput("sr_w_valid", {31'b0, bus.w_valid}, 32'd0);
        checkOutput("sr_count", {16'b0, burst_count}, 32'd0);
        checkOutput("sr_fifo_left", fifoQ.size(), 5);
        applyStimulus(3);
        en = 1'b1;
        watchBurst(16'h0000, 4'd7, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("sr_count_1", {16'b0, burst_count}, 32'd1);

        // Asynchronous reset mid-burst, checked without a clock edge
        applyStimulus(8);
        waitAw(40);
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        bus.w_ready = 1'b1;
        tick();
        tick();
        checkOutput("ar_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("ar_busy", {31'b0, busy}, 32'd0);
        checkOutput("ar_w_valid", {31'b0, bus.w_valid}, 32'd0);
        checkOutput("ar_aw_valid", {31'b0, bus.aw_valid}, 32'd0);
        checkOutput("ar_fifo_re", {31'b0, fifo_re}, 32'd0);
        checkOutput("ar_count", {16'b0, burst_count}, 32'd0);
        bus.w_ready = 1'b0;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
